adi_alu: RTL and testbench

Registered, single-cycle-latency arithmetic/logic unit operating on two unsigned WIDTH-bit operands and producing a 2·WIDTH-bit result. It also raises a division-by-zero flag. It sits as a leaf datapath block driven by a controller or testbench interface. A new opcode and operands may be presented every clock.

---
 rtl/adi_alu_if.sv | 27 ++
 rtl/adi_alu.sv | 87 ++++++++
 tb/tb_adi_alu.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adi_alu_if.sv
// Operand/opcode bus and registered result for adi_alu.
// The master drives Opcode/A/B; the ALU (slave) returns C and Division_by_Zero.
interface adi_alu_if #(
    parameter int unsigned WIDTH = 8
);
    logic [3:0]         Opcode;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2*WIDTH-1:0] C;
    logic               Division_by_Zero;

    modport master (
        output Opcode,
        output A,
        output B,
        input  C,
        input  Division_by_Zero
    );

    modport slave (
        input  Opcode,
        input  A,
        input  B,
        output C,
        output Division_by_Zero
    );
endinterface

// File: rtl/adi_alu.sv
// Registered single-cycle ALU with a 2*WIDTH result and a division-by-zero flag.
// Define ALU_DIV_EN to build the divider for DIV/MOD; otherwise both return 0 with no flag.
module adi_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    adi_alu_if.slave  bus
);
    localparam int unsigned ShW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpMul  = 4'd2,
        OpDiv  = 4'd3,
        OpMod  = 4'd4,
        OpAnd  = 4'd5,
        OpOr   = 4'd6,
        OpXor  = 4'd7,
        OpNand = 4'd8,
        OpNor  = 4'd9,
        OpXnor = 4'd10,
        OpNot  = 4'd11,
        OpShl  = 4'd12,
        OpShr  = 4'd13,
        OpEq   = 4'd14,
        OpGt   = 4'd15
    } op_e;

    logic [2*WIDTH-1:0] a_x, b_x;
    logic [2*WIDTH-1:0] c_d, c_q;
    logic               dbz_d, dbz_q;
    logic [ShW-1:0]     sh_amt;

    assign a_x    = {{WIDTH{1'b0}}, bus.A};
    assign b_x    = {{WIDTH{1'b0}}, bus.B};
    assign sh_amt = bus.B[ShW-1:0];

    always_comb begin
        c_d   = '0;
        dbz_d = 1'b0;
        unique case (op_e'(bus.Opcode))
            OpAdd:  c_d = a_x + b_x;
            OpSub:  c_d = a_x - b_x;
            OpMul:  c_d = a_x * b_x;
`ifdef ALU_DIV_EN
            OpDiv: begin
                if (bus.B == '0) dbz_d = 1'b1;
                else             c_d   = a_x / b_x;
            end
            OpMod: begin
                if (bus.B == '0) dbz_d = 1'b1;
                else             c_d   = a_x % b_x;
            end
`else
            OpDiv, OpMod: c_d = '0;
`endif
            OpAnd:  c_d = {{WIDTH{1'b0}}, bus.A & bus.B};
            OpOr:   c_d = {{WIDTH{1'b0}}, bus.A | bus.B};
            OpXor:  c_d = {{WIDTH{1'b0}}, bus.A ^ bus.B};
            OpNand: c_d = {{WIDTH{1'b0}}, ~(bus.A & bus.B)};
            OpNor:  c_d = {{WIDTH{1'b0}}, ~(bus.A | bus.B)};
            OpXnor: c_d = {{WIDTH{1'b0}}, ~(bus.A ^ bus.B)};
            OpNot:  c_d = {{WIDTH{1'b0}}, ~bus.A};
            // Shift in the widened domain so SHL never drops bits.
            OpShl:  c_d = a_x << sh_amt;
            OpShr:  c_d = a_x >> sh_amt;
            OpEq:   c_d = {{(2*WIDTH-1){1'b0}}, bus.A == bus.B};
            OpGt:   c_d = {{(2*WIDTH-1){1'b0}}, bus.A > bus.B};
            default: c_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_q   <= '0;
            dbz_q <= 1'b0;
        end else begin
            c_q   <= c_d;
            dbz_q <= dbz_d;
        end
    end

    assign bus.C                = c_q;
    assign bus.Division_by_Zero = dbz_q;
endmodule

// File: tb/tb_adi_alu.sv
// Directed and randomized self-checking bench for adi_alu at WIDTH = 8.
// Expectations for DIV/MOD follow whether ALU_DIV_EN is defined for this build.
module tb_adi_alu;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    adi_alu_if #(.WIDTH(8)) bus ();

    adi_alu #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: integer arithmetic, masked to 16 bits.
    function automatic logic [16:0] model(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        int unsigned ai, bi, r;
        logic        z;
        ai = a;
        bi = b;
        r  = 0;
        z  = 1'b0;
        case (op)
            4'd0:  r = ai + bi;
            4'd1:  r = (ai + 32'd65536 - bi) & 32'hFFFF;
            4'd2:  r = ai * bi;
`ifdef ALU_DIV_EN
            4'd3:  if (bi == 0) z = 1'b1; else r = ai / bi;
            4'd4:  if (bi == 0) z = 1'b1; else r = ai % bi;
`else
            4'd3, 4'd4: r = 0;
`endif
            4'd5:  r = ai & bi;
            4'd6:  r = ai | bi;
            4'd7:  r = ai ^ bi;
            4'd8:  r = 32'hFF - (ai & bi);
            4'd9:  r = 32'hFF - (ai | bi);
            4'd10: r = 32'hFF - (ai ^ bi);
            4'd11: r = 32'hFF - ai;
            4'd12: r = ai * (32'd1 << (bi % 8));
            4'd13: r = ai / (32'd1 << (bi % 8));
            4'd14: r = (ai == bi) ? 1 : 0;
            4'd15: r = (ai > bi) ? 1 : 0;
            default: r = 0;
        endcase
        return {r[15:0], z};
    endfunction

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.Opcode = op;
        bus.A      = a;
        bus.B      = b;
    endtask

    // Drive at the falling edge, then sample 1 time unit past the capturing edge.
    task automatic step(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        drive(op, a, b);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(4'd0, 8'd3, 8'd4);
        for (int i = 0; i < 4; i++) begin
            #5;
            vectors++;
            if (bus.C !== 16'h0000 || bus.Division_by_Zero !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: C=%h flag=%b expected C=0000 flag=0",
                         i, bus.C, bus.Division_by_Zero);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.C !== 16'h0007 || bus.Division_by_Zero !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: C=%h flag=%b expected C=0007 flag=0",
                     bus.C, bus.Division_by_Zero);
        end
    endtask

    task automatic test_arith();
        step(4'd0, 8'd200, 8'd100);
        vectors++;
        if (bus.C !== 16'h012C) begin
            miscompares++;
            $display("FAIL add_200_100: C=%h expected 012C", bus.C);
        end
        drive(4'd1, 8'd5, 8'd7);
        vectors++;
        if (bus.C !== 16'h012C) begin
            miscompares++;
            $display("FAIL latency_hold: C=%h expected 012C before edge", bus.C);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.C !== 16'hFFFE) begin
            miscompares++;
            $display("FAIL sub_5_7: C=%h expected FFFE", bus.C);
        end
        step(4'd2, 8'd255, 8'd255);
        vectors++;
        if (bus.C !== 16'hFE01) begin
            miscompares++;
            $display("FAIL mul_255_255: C=%h expected FE01", bus.C);
        end
    endtask

    task automatic test_divide();
        logic [15:0] e_div, e_mod;
        logic        e_z;
`ifdef ALU_DIV_EN
        e_div = 16'h000E;
        e_mod = 16'h0002;
        e_z   = 1'b1;
`else
        e_div = 16'h0000;
        e_mod = 16'h0000;
        e_z   = 1'b0;
`endif
        step(4'd3, 8'd100, 8'd7);
        vectors++;
        if (bus.C !== e_div || bus.Division_by_Zero !== 1'b0) begin
            miscompares++;
            $display("FAIL div_100_7: C=%h flag=%b expected C=%h flag=0",
                     bus.C, bus.Division_by_Zero, e_div);
        end
        step(4'd4, 8'd100, 8'd7);
        vectors++;
        if (bus.C !== e_mod || bus.Division_by_Zero !== 1'b0) begin
            miscompares++;
            $display("FAIL mod_100_7: C=%h flag=%b expected C=%h flag=0",
                     bus.C, bus.Division_by_Zero, e_mod);
        end
        step(4'd3, 8'd9, 8'd0);
        vectors++;
        if (bus.C !== 16'h0000 || bus.Division_by_Zero !== e_z) begin
            miscompares++;
            $display("FAIL div_9_0: C=%h flag=%b expected C=0000 flag=%b",
                     bus.C, bus.Division_by_Zero, e_z);
        end
        step(4'd0, 8'd1, 8'd1);
        vectors++;
        if (bus.C !== 16'h0002 || bus.Division_by_Zero !== 1'b0) begin
            miscompares++;
            $display("FAIL add_after_dbz: C=%h flag=%b expected C=0002 flag=0",
                     bus.C, bus.Division_by_Zero);
        end
    endtask

    task automatic test_logic();
        logic [3:0]  ops  [6] = '{4'd5,   4'd11,  4'd12,  4'd13,  4'd14,  4'd15};
        logic [7:0]  as   [6] = '{8'hF0,  8'h0F,  8'h81,  8'h81,  8'd5,   8'd4};
        logic [7:0]  bs   [6] = '{8'h3C,  8'h00,  8'd3,   8'd3,   8'd5,   8'd9};
        logic [15:0] exps [6] = '{16'h0030, 16'h00F0, 16'h0408, 16'h0010, 16'h0001,
                                  16'h0000};
        for (int i = 0; i < 6; i++) begin
            step(ops[i], as[i], bs[i]);
            vectors++;
            if (bus.C !== exps[i] || bus.Division_by_Zero !== 1'b0) begin
                miscompares++;
                $display("FAIL logic[%0d] op=%0d: C=%h flag=%b expected C=%h flag=0",
                         i, ops[i], bus.C, bus.Division_by_Zero, exps[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  op;
        logic [7:0]  a, b;
        logic [16:0] exp;
        for (int i = 0; i < 1200; i++) begin
            op = 4'($urandom_range(15, 0));
            a  = 8'($urandom_range(255, 0));
            b  = (i % 16 == 0) ? 8'd0 : 8'($urandom_range(255, 0));
            exp = model(op, a, b);
            step(op, a, b);
            vectors++;
            if ({bus.C, bus.Division_by_Zero} !== exp) begin
                miscompares++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: C=%h flag=%b expected C=%h flag=%b",
                         i, op, a, b, bus.C, bus.Division_by_Zero, exp[16:1], exp[0]);
            end
        end
    endtask

    task automatic test_async_reset();
        step(4'd0, 8'd200, 8'd100);
        #3;
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.C !== 16'h0000 || bus.Division_by_Zero !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: C=%h flag=%b expected C=0000 flag=0",
                     bus.C, bus.Division_by_Zero);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.C !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_held_edge: C=%h expected 0000", bus.C);
        end
        @(negedge clk);
        reset = 1'b1;
        step(4'd7, 8'hAA, 8'h0F);
        vectors++;
        if (bus.C !== 16'h00A5) begin
            miscompares++;
            $display("FAIL xor_after_reset: C=%h expected 00A5", bus.C);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        bus.Opcode  = 4'd0;
        bus.A       = 8'd0;
        bus.B       = 8'd0;
        test_reset();
        test_arith();
        test_divide();
        test_logic();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
